// File: rtl/pipeline_defs_pkg.sv
// pipeline_defs: shared state encodings, register-number width and valid-vector stage indices.
package pipeline_defs;
  typedef enum logic {RUN, MD_BUSY} state_e;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  localparam int V_ID = 0;
  localparam int V_EX = 1;
  localparam int V_MEM = 2;
  localparam int V_WB = 3;
endpackage

// File: rtl/hazard_stat_counter.sv
// hazard_stat_counter: 32-bit saturating event counter with synchronous clear.
module hazard_stat_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  output logic [31:0] count
);
  logic [31:0] count_q, count_d;
  always_comb count_d = reset ? '0 : (inc & ~&count_q) ? count_q + 32'd1 : count_q;
  always_ff @(posedge clock) count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC/IF-ID/ID-EX/EX-MEM stall, bubble and flush control with stage-valid tracking.
// Define HAZARD_STATS_EN to build the stall-cycle and flush counters.
module pipeline_hazard_ctrl
  import pipeline_defs::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             md_start,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_clear,
  output logic             id_ex_enable,
  output logic             id_ex_clear,
  output logic             ex_mem_clear,
  output logic             md_busy,
  output logic [3:0]       valid,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
);
  localparam logic MD_EN = MD_LATENCY > 1;
  localparam logic MD_MULTI = MD_LATENCY > 2;
  state_e state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [3:0] valid_q, valid_d;
  logic md_hit, lu_hit, br_hit, md_stall;
  always_comb begin
    md_hit = (state_q == RUN) & md_start & valid_q[V_EX] & MD_EN;
    lu_hit = ex_mem_read & valid_q[V_EX] & valid_q[V_ID] & (ex_rt != REG_ZERO) &
             ((ex_rt == id_rs) | (ex_rt == id_rt));
    br_hit = branch_taken & valid_q[V_ID];
    md_stall = md_hit | (state_q == MD_BUSY);
    pc_enable = reset | ~(md_stall | lu_hit);
    if_id_enable = pc_enable;
    if_id_clear = reset | (~md_stall & ~lu_hit & br_hit);
    id_ex_enable = reset | ~md_stall;
    id_ex_clear = reset | (~md_stall & lu_hit);
    ex_mem_clear = reset | md_stall;
    md_busy = ~reset & md_stall;
    // Leaving MD_BUSY as the count reaches zero gives MD_LATENCY-1 stall cycles in total.
    state_d = reset ? RUN :
              (state_q == MD_BUSY) ? ((md_cnt_q <= CNT_W'(1)) ? RUN : MD_BUSY) :
              (md_hit & MD_MULTI) ? MD_BUSY : RUN;
    md_cnt_d = reset ? '0 :
               (state_q == MD_BUSY) ? md_cnt_q - CNT_W'(1) :
               (md_hit & MD_MULTI) ? CNT_W'(MD_LATENCY - 2) : md_cnt_q;
    valid_d = reset ? '0 : {valid_q[V_MEM],
                            valid_q[V_EX] & ~ex_mem_clear,
                            id_ex_enable ? (valid_q[V_ID] & ~id_ex_clear) : valid_q[V_EX],
                            if_id_enable ? ~if_id_clear : valid_q[V_ID]};
  end
  always_ff @(posedge clock) begin
    state_q <= state_d;
    md_cnt_q <= md_cnt_d;
    valid_q <= valid_d;
  end
  assign valid = valid_q;
`ifdef HAZARD_STATS_EN
  hazard_stat_counter u_stall_cnt (
    .clock(clock), .reset(reset), .inc(~pc_enable), .count(stall_cycles)
  );
  hazard_stat_counter u_flush_cnt (
    .clock(clock), .reset(reset), .inc(if_id_clear | id_ex_clear), .count(flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for pipeline_hazard_ctrl (MD_LATENCY=4 plus a MD_LATENCY=1 copy).
module tb_pipeline_hazard_ctrl;
  typedef struct {
    string tag;
    logic [10:0] exp;
  } item_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic ex_mem_read = 1'b0, branch_taken = 1'b0, md_start = 1'b0;
  logic pc_enable, if_id_enable, if_id_clear, id_ex_enable, id_ex_clear, ex_mem_clear, md_busy;
  logic [3:0] valid;
  logic [31:0] stall_cycles, flush_count;
  logic pc_enable1, if_id_enable1, if_id_clear1, id_ex_enable1, id_ex_clear1, ex_mem_clear1, md_busy1;
  logic [3:0] valid1;
  logic [31:0] stall_cycles1, flush_count1;
  logic [10:0] obs;
  item_t sb[$];
  int errors = 0;
  int checks = 0;
`ifdef HAZARD_STATS_EN
  localparam logic [31:0] EXP_STALLS = 32'd6;
  localparam logic [31:0] EXP_FLUSHES = 32'd4;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
  localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif
  localparam logic [5:0] RST = 6'b111111;
  localparam logic [5:0] NRM = 6'b110100;
  localparam logic [5:0] LU = 6'b000110;
  localparam logic [5:0] BR = 6'b111100;
  localparam logic [5:0] MD = 6'b000001;

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_taken(branch_taken), .md_start(md_start), .pc_enable(pc_enable),
    .if_id_enable(if_id_enable), .if_id_clear(if_id_clear), .id_ex_enable(id_ex_enable),
    .id_ex_clear(id_ex_clear), .ex_mem_clear(ex_mem_clear), .md_busy(md_busy), .valid(valid),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  pipeline_hazard_ctrl #(.MD_LATENCY(1), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_taken(branch_taken), .md_start(md_start), .pc_enable(pc_enable1),
    .if_id_enable(if_id_enable1), .if_id_clear(if_id_clear1), .id_ex_enable(id_ex_enable1),
    .id_ex_clear(id_ex_clear1), .ex_mem_clear(ex_mem_clear1), .md_busy(md_busy1), .valid(valid1),
    .stall_cycles(stall_cycles1), .flush_count(flush_count1)
  );

  always #5 clock = ~clock;
  assign obs = {pc_enable, if_id_enable, if_id_clear, id_ex_enable, id_ex_clear, ex_mem_clear, md_busy, valid};

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic mr, input logic [4:0] ert, input logic br, input logic md,
                      input logic [5:0] ctl, input logic mb, input logic [3:0] v);
    item_t it;
    @(negedge clock);
    reset = r;
    id_rs = rs;
    id_rt = rt;
    ex_mem_read = mr;
    ex_rt = ert;
    branch_taken = br;
    md_start = md;
    sb.push_back('{tag, {ctl, mb, v}});
    #2;
    it = sb.pop_front();
    checks++;
    assert (obs === it.exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", it.tag, obs, it.exp);
    end
  endtask

  initial begin
    @(posedge clock);
    step("rst1", 1, 1, 2, 0, 3, 0, 0, RST, 0, 4'b0000);
    step("rst2", 1, 1, 2, 0, 3, 0, 0, RST, 0, 4'b0000);
    step("run0", 0, 1, 2, 0, 3, 0, 0, NRM, 0, 4'b0000);
    step("run1", 0, 1, 2, 0, 3, 0, 0, NRM, 0, 4'b0001);
    step("run2", 0, 1, 2, 0, 3, 0, 0, NRM, 0, 4'b0011);
    step("run3", 0, 1, 2, 0, 3, 0, 0, NRM, 0, 4'b0111);
    step("run4", 0, 1, 2, 0, 3, 0, 0, NRM, 0, 4'b1111);
    step("lu_rs", 0, 8, 2, 1, 8, 0, 0, LU, 0, 4'b1111);
    step("lu_after", 0, 8, 2, 1, 8, 0, 0, NRM, 0, 4'b1101);
    step("lu_r0", 0, 0, 2, 1, 0, 0, 0, NRM, 0, 4'b1011);
    step("lu_rt", 0, 1, 9, 1, 9, 0, 0, LU, 0, 4'b0111);
    step("idle", 0, 1, 2, 0, 3, 0, 0, NRM, 0, 4'b1101);
    step("idle2", 0, 1, 2, 0, 3, 0, 0, NRM, 0, 4'b1011);
    step("lu_br", 0, 8, 2, 1, 8, 1, 0, LU, 0, 4'b0111);
    step("br_held", 0, 8, 2, 1, 8, 1, 0, BR, 0, 4'b1101);
    step("br_off", 0, 1, 2, 0, 3, 0, 0, NRM, 0, 4'b1010);
    step("fill", 0, 1, 2, 0, 3, 0, 0, NRM, 0, 4'b0101);
    step("md0", 0, 1, 2, 0, 3, 0, 1, MD, 1, 4'b1011);
    chk("md_lat1", {pc_enable1, md_busy1}, 64'h2);
    step("md1", 0, 1, 2, 0, 3, 0, 1, MD, 1, 4'b0011);
    step("md2", 0, 1, 2, 0, 3, 0, 1, MD, 1, 4'b0011);
    step("md_done", 0, 1, 2, 0, 3, 0, 0, NRM, 0, 4'b0011);
    chk("stall_cycles", stall_cycles, EXP_STALLS);
    chk("flush_count", flush_count, EXP_FLUSHES);
    step("md_b0", 0, 1, 2, 0, 3, 0, 1, MD, 1, 4'b0111);
    step("md_b1", 0, 1, 2, 0, 3, 0, 1, MD, 1, 4'b1011);
    step("md_rst", 1, 1, 2, 0, 3, 0, 1, RST, 0, 4'b0011);
    step("post_rst", 0, 1, 2, 0, 3, 0, 1, NRM, 0, 4'b0000);
    chk("stall_clr", stall_cycles, 64'h0);
    chk("flush_clr", flush_count, 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
